// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests, sequences exception flushes
// (deferring those raised while MEM waits on the bus) and tracks stall statistics.
module pipe_ctrl #(
    parameter logic [31:0]          EXC_VECTOR    = 32'h0000_0020,
    parameter int unsigned          TIMEOUT_W     = 16,
    parameter logic [TIMEOUT_W-1:0] STALL_TIMEOUT = TIMEOUT_W'(16'hFFFF),
    localparam int unsigned         XLEN          = 32,
    localparam int unsigned         STALL_W       = 6,
    localparam int unsigned         CNT_W         = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_stallreq_id,
    input  logic               i_stallreq_ex,
    input  logic               i_stallreq_mem,
    input  logic               i_excp_valid,
    input  logic [XLEN-1:0]    i_excp_type,
    input  logic [XLEN-1:0]    i_cp0_epc,
    output logic [STALL_W-1:0] o_stall,
    output logic               o_flush,
    output logic [XLEN-1:0]    o_new_pc,
    output logic [CNT_W-1:0]   o_stall_cnt,
    output logic               o_stall_timeout
);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_WAIT_MEM = 1'b1
    } state_t;

    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
    localparam logic [XLEN-1:0]    EXC_ERET   = 32'h0000_000E;

    state_t               r_state;
    state_t               w_state_next;
    logic [XLEN-1:0]      r_excp_type;
    logic [XLEN-1:0]      r_excp_epc;
    logic [CNT_W-1:0]     r_stall_cnt;
    logic [TIMEOUT_W-1:0] r_consec;
    logic                 r_stall_timeout;

    logic [STALL_W-1:0]   w_req_stall;
    logic [STALL_W-1:0]   w_stall;
    logic                 w_flush;
    logic [XLEN-1:0]      w_new_pc;
    logic                 w_latch_en;
    logic                 w_stalled;
    logic [TIMEOUT_W-1:0] w_consec_inc;
    logic                 w_timeout_hit;

    // eret returns to EPC; every other exception goes to the common vector
    function automatic logic [XLEN-1:0] redirect_pc(input logic [XLEN-1:0] typ,
                                                    input logic [XLEN-1:0] epc);
        return (typ == EXC_ERET) ? epc : EXC_VECTOR;
    endfunction

    // Stall request merge, deepest stage wins
    always_comb begin
        w_req_stall = STALL_NONE;
        if (i_stallreq_mem) begin
            w_req_stall = STALL_MEM;
        end else if (i_stallreq_ex) begin
            w_req_stall = STALL_EX;
        end else if (i_stallreq_id) begin
            w_req_stall = STALL_ID;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (i_excp_valid && i_stallreq_mem) begin
                    w_state_next = ST_WAIT_MEM;
                end
            end
            ST_WAIT_MEM: begin
                if (!i_stallreq_mem) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    // Zero-latency stall/flush/redirect; a flush always overrides stall requests
    always_comb begin
        w_stall    = w_req_stall;
        w_flush    = 1'b0;
        w_new_pc   = '0;
        w_latch_en = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_excp_valid && !i_stallreq_mem) begin
                    w_stall  = STALL_NONE;
                    w_flush  = 1'b1;
                    w_new_pc = redirect_pc(i_excp_type, i_cp0_epc);
                end else if (i_excp_valid) begin
                    w_latch_en = 1'b1;
                end
            end
            ST_WAIT_MEM: begin
                if (!i_stallreq_mem) begin
                    w_stall  = STALL_NONE;
                    w_flush  = 1'b1;
                    w_new_pc = redirect_pc(r_excp_type, r_excp_epc);
                end
            end
            default: begin
                w_stall = w_req_stall;
            end
        endcase
        if (i_rst) begin
            w_stall    = STALL_NONE;
            w_flush    = 1'b0;
            w_new_pc   = '0;
            w_latch_en = 1'b0;
        end
    end

    // Exception captured while MEM is stalled; redirect later uses these copies
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_excp_type <= '0;
            r_excp_epc  <= '0;
        end else if (w_latch_en) begin
            r_excp_type <= i_excp_type;
            r_excp_epc  <= i_cp0_epc;
        end
    end

    assign w_stalled    = w_stall[0];
    assign w_consec_inc = r_consec + TIMEOUT_W'(1);
    assign w_timeout_hit = w_stalled &&
                           ((r_consec == STALL_TIMEOUT) || (w_consec_inc == STALL_TIMEOUT));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if (w_stalled && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // Consecutive-stall run length; a flush cycle never stalls so it clears too
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_consec        <= '0;
            r_stall_timeout <= 1'b0;
        end else begin
            if (!w_stalled) begin
                r_consec <= '0;
            end else if (r_consec != STALL_TIMEOUT) begin
                r_consec <= w_consec_inc;
            end
            if (w_timeout_hit) begin
                r_stall_timeout <= 1'b1;
            end
        end
    end

    assign o_stall         = w_stall;
    assign o_flush         = w_flush;
    assign o_new_pc        = w_new_pc;
    assign o_stall_cnt     = r_stall_cnt;
    assign o_stall_timeout = r_stall_timeout;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios followed by random traffic, all checked
// against an exception/stall reference model kept in the bench.
module tb_pipe_ctrl;

    localparam int unsigned TO = 5;

    logic        clk = 1'b0;
    logic        rst, stallreq_id, stallreq_ex, stallreq_mem, excp_valid;
    logic [31:0] excp_type, cp0_epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc, stall_cnt;
    logic        stall_timeout;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit          m_pend;
    logic [31:0] m_ptype, m_pepc;
    logic [31:0] m_cnt;
    int          m_consec;
    bit          m_to;

    // values observed during the most recent step
    logic [5:0]  s_stall;
    logic        s_flush, s_to;
    logic [31:0] s_pc, s_cnt, c0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .EXC_VECTOR   (32'h0000_0020),
        .TIMEOUT_W    (16),
        .STALL_TIMEOUT(16'(TO))
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_stallreq_id  (stallreq_id),
        .i_stallreq_ex  (stallreq_ex),
        .i_stallreq_mem (stallreq_mem),
        .i_excp_valid   (excp_valid),
        .i_excp_type    (excp_type),
        .i_cp0_epc      (cp0_epc),
        .o_stall        (stall),
        .o_flush        (flush),
        .o_new_pc       (new_pc),
        .o_stall_cnt    (stall_cnt),
        .o_stall_timeout(stall_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] target(input logic [31:0] t, input logic [31:0] e);
        return (t == 32'h0000_000E) ? e : 32'h0000_0020;
    endfunction

    // One clock cycle: drive, check combinational and registered outputs, advance model
    task automatic step(input int r, input int id, input int ex, input int mem,
                        input int ev, input logic [31:0] t, input logic [31:0] e);
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        rst = (r != 0); stallreq_id = (id != 0); stallreq_ex = (ex != 0);
        stallreq_mem = (mem != 0); excp_valid = (ev != 0);
        excp_type = t; cp0_epc = e;
        #2;
        e_stall = 6'b0; e_flush = 1'b0; e_pc = 32'h0;
        if (r == 0) begin
            if (m_pend) begin
                if (mem != 0) e_stall = 6'b011111;
                else begin e_flush = 1'b1; e_pc = target(m_ptype, m_pepc); end
            end else if (ev != 0 && mem == 0) begin
                e_flush = 1'b1; e_pc = target(t, e);
            end else if (mem != 0) e_stall = 6'b011111;
            else if (ex != 0)      e_stall = 6'b001111;
            else if (id != 0)      e_stall = 6'b000111;
        end
        s_stall = stall; s_flush = flush; s_pc = new_pc; s_cnt = stall_cnt; s_to = stall_timeout;
        chk("stall", 32'(s_stall), 32'(e_stall));
        chk("flush", 32'(s_flush), 32'(e_flush));
        if (r != 0 || e_flush) chk("new_pc", s_pc, e_pc);
        chk("stall_cnt", s_cnt, m_cnt);
        chk("stall_timeout", 32'(s_to), 32'(m_to));
        @(posedge clk);
        #1;
        if (r != 0) begin
            m_pend = 0; m_ptype = 0; m_pepc = 0; m_cnt = 0; m_consec = 0; m_to = 0;
        end else begin
            if (e_stall[0]) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (m_consec + 1 >= int'(TO)) m_to = 1;
                if (m_consec < int'(TO)) m_consec = m_consec + 1;
            end else begin
                m_consec = 0;
            end
            if (m_pend) begin
                if (mem == 0) m_pend = 0;
            end else if (ev != 0 && mem != 0) begin
                m_pend = 1; m_ptype = t; m_pepc = e;
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] types [7];
        logic [31:0] rt;
        types = '{32'h1, 32'h8, 32'hA, 32'hD, 32'hC, 32'hE, 32'h0};
        rst = 1'b1; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        excp_valid = 0; excp_type = 0; cp0_epc = 0;
        m_pend = 0; m_ptype = 0; m_pepc = 0; m_cnt = 0; m_consec = 0; m_to = 0;
        repeat (2) @(posedge clk);
        #1;

        // reset then idle
        step(1, 0, 0, 0, 0, 32'h0, 32'h0);
        repeat (10) idle();
        chk("idle_cnt", s_cnt, 32'h0);

        // stall priority and stall counting
        c0 = s_cnt;
        repeat (2) begin
            step(0, 1, 1, 0, 0, 32'h0, 32'h0);
            chk("prio_id_ex", 32'(s_stall), 32'h0F);
        end
        repeat (2) begin
            step(0, 1, 1, 1, 0, 32'h0, 32'h0);
            chk("prio_mem", 32'(s_stall), 32'h1F);
        end
        idle();
        chk("prio_none", 32'(s_stall), 32'h0);
        chk("prio_cnt_delta", s_cnt - c0, 32'd4);

        // plain exception and eret
        step(0, 1, 1, 0, 1, 32'h8, 32'h0);
        chk("syscall_pc", s_pc, 32'h20);
        chk("syscall_stall", 32'(s_stall), 32'h0);
        step(0, 0, 0, 0, 1, 32'hE, 32'h0000_1234);
        chk("eret_pc", s_pc, 32'h1234);
        idle();

        // deferred exception while MEM is stalled
        step(0, 0, 0, 1, 1, 32'hC, 32'hABCD_0000);
        chk("defer_c1_stall", 32'(s_stall), 32'h1F);
        repeat (2) begin
            step(0, 0, 1, 1, 1, 32'hE, 32'h0);
            chk("defer_hold_flush", 32'(s_flush), 32'h0);
        end
        step(0, 0, 1, 0, 1, 32'hE, 32'h0);
        chk("defer_flush", 32'(s_flush), 32'h1);
        chk("defer_pc", s_pc, 32'h20);
        idle();
        chk("defer_single_flush", 32'(s_flush), 32'h0);

        // back-to-back exceptions each flush
        step(0, 0, 0, 0, 1, 32'hA, 32'h0);
        step(0, 0, 0, 0, 1, 32'hD, 32'h0);
        chk("b2b_flush", 32'(s_flush), 32'h1);

        // interrupted stall run never times out
        step(1, 0, 0, 0, 0, 32'h0, 32'h0);
        repeat (2) step(0, 0, 1, 0, 0, 32'h0, 32'h0);
        idle();
        repeat (3) step(0, 0, 1, 0, 0, 32'h0, 32'h0);
        repeat (2) idle();
        chk("gap_no_timeout", 32'(s_to), 32'h0);

        // continuous stall run reaches the timeout and stays sticky
        repeat (5) step(0, 0, 1, 0, 0, 32'h0, 32'h0);
        chk("timeout_c5", 32'(s_to), 32'h0);
        idle();
        chk("timeout_c6", 32'(s_to), 32'h1);
        repeat (3) idle();
        chk("timeout_sticky", 32'(s_to), 32'h1);

        // reset while an exception is pending drops it
        step(0, 0, 0, 1, 1, 32'h8, 32'h0);
        step(0, 0, 0, 1, 0, 32'h0, 32'h0);
        step(1, 0, 0, 1, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0, 32'h0);
        chk("rst_drop_flush", 32'(s_flush), 32'h0);
        chk("rst_drop_stall", 32'(s_stall), 32'h0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rt = types[$urandom_range(0, 6)];
            if (rt == 32'h0) rt = $urandom;
            step(($urandom_range(0, 63) == 0) ? 1 : 0,
                 ($urandom_range(0, 3) == 0) ? 1 : 0,
                 ($urandom_range(0, 4) == 0) ? 1 : 0,
                 ($urandom_range(0, 2) == 0) ? 1 : 0,
                 ($urandom_range(0, 5) == 0) ? 1 : 0,
                 rt, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage core. Merges per-stage stall requests into the 6-bit stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
- Sequences exception flushes, including exceptions raised while MEM is stalled on the bus: these are deferred and the redirect is computed from captured values.
- Provides a saturating stall-cycle statistic and a sticky stall-timeout flag.

Parameters:
- EXC_VECTOR, 32'h0000_0020, redirect PC for all non-eret exceptions.
- TIMEOUT_W, 16, width of the consecutive-stall counter.
- STALL_TIMEOUT, 16'hFFFF, consecutive stalled cycles that set stall_timeout.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- stallreq_id  in  1  ID requests stall (load-use hazard).
- stallreq_ex  in  1  EX requests stall (multi-cycle div/madd).
- stallreq_mem  in  1  MEM requests stall (data bus not ready).
- excp_valid  in  1  MEM-stage instruction carries an exception.
- excp_type  in  32  exception code: 1 int, 8 syscall, a invalid, d trap, c overflow, e eret.
- cp0_epc  in  32  current EPC from CP0.
- stall  out  6  [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb; 1 = hold.
- flush  out  1  clear all pipeline registers this cycle.
- new_pc  out  32  redirect target, valid when flush=1.
- stall_cnt  out  32  cycles with stall[0]=1 since reset, saturating.
- stall_timeout  out  1  sticky: consecutive stall reached STALL_TIMEOUT.

Behaviour:
- States: RUN, WAIT_MEM. Reset enters RUN.
- rst=1: stall=0, flush=0, new_pc=0 (forced combinationally during reset). State=RUN, latched type/epc=0, stall_cnt=0, consecutive counter=0, stall_timeout=0.
- stall, flush and new_pc are combinational from inputs and state, with zero latency.
- Stall priority, MEM > EX > ID:
  - stallreq_mem gives 6'b011111.
  - else stallreq_ex gives 6'b001111.
  - else stallreq_id gives 6'b000111.
  - else 6'b000000.
- stall[5] is always 0. With stall[4]=1, mem_wb inserts a bubble.
- RUN, excp_valid=1, stallreq_mem=0:
  - flush=1, stall=0.
  - new_pc=cp0_epc if excp_type==32'he, else EXC_VECTOR.
  - Stay in RUN.
- RUN, excp_valid=1, stallreq_mem=1:
  - flush=0, stall=011111.
  - Latch excp_type and cp0_epc, go to WAIT_MEM.
- WAIT_MEM, stallreq_mem=1: stall=011111, flush=0. Latched values held; excp_valid and new inputs are ignored.
- WAIT_MEM, stallreq_mem=0:
  - flush=1, stall=0, new_pc from the latched type/epc (same mapping as RUN).
  - Next state RUN.
- Flush has priority over stallreq_id and stallreq_ex: stall=0 whenever flush=1.
- At most one flush per exception. Back-to-back exceptions in consecutive RUN cycles each flush.
- stall_cnt: +1 each cycle with stall[0]=1; saturates at 32'hFFFF_FFFF.
- Consecutive counter (TIMEOUT_W bits):
  - +1 each stalled cycle; cleared on any cycle with stall[0]=0 or flush=1.
  - When it equals STALL_TIMEOUT, stall_timeout goes to 1 (registered, visible the next cycle) and the counter saturates.
  - stall_timeout is cleared only by rst.
- rst asserted mid-WAIT_MEM drops the pending exception: no flush after reset release.

Test Plan:
- Reset then idle: all requests 0 -> stall=000000, flush=0, new_pc=0, stall_cnt=0 for 10 cycles.
- Priority: id+ex asserted together -> 001111; add mem -> 011111; drop all -> 000000. stall_cnt increments by exactly the number of stalled cycles.
- Plain exception: excp_valid=1, excp_type=32'h8, stallreq_mem=0 -> same-cycle flush=1, new_pc=32'h20, stall=0. Then eret (type e, epc=32'h0000_1234) -> new_pc=32'h1234.
- Deferred: excp_valid=1, type=c, epc=32'hABCD0000, stallreq_mem=1 for 3 cycles, inputs changed to type e / epc=0 after cycle 1:
  - 3 cycles of stall=011111, flush=0.
  - Cycle 4: stallreq_mem=0 -> flush=1, new_pc=32'h20.
- Timeout: STALL_TIMEOUT=5, stallreq_ex held 5 cycles -> stall_timeout=1 from cycle 6 and stays set after release.
  - Repeat with a 1-cycle gap at cycle 3 -> stall_timeout stays 0.
- Reset in WAIT_MEM: enter WAIT_MEM, pulse rst, release with stallreq_mem=0 -> no flush, stall=0.
